rr_arbiter4: RTL and testbench
==============================

# rr_arbiter4

Four-requester round-robin arbiter that shares a single downstream resource (bus, encoder datapath, shared register port) among four clients. It produces a registered one-hot grant plus its 2-bit binary index, which is the same 4-to-2 encoding the datapath already uses. A grant is held while its owner keeps requesting, bounded by a programmable hold limit so that no client can starve the others. The arbiter sits between the requesting clients and the shared resource's select input.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles before a forced rotation; 0 means unlimited hold.
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  request vector; bit i is client i; level-sensitive.
- `gnt`  out  4  registered one-hot grant; all-zero when idle.
- `gnt_idx`  out  2  binary index of the granted client; 0 when idle.
- `gnt_valid`  out  1  high when `gnt` is nonzero.
- `preempt`  out  1  one-cycle pulse, high in the first cycle of a grant that came from a forced rotation.

## Operation
- Internal state:
  - FSM states IDLE and BUSY.
  - `ptr[1:0]`: next highest-priority client.
  - `owner[1:0]`: current grant holder.
  - `hold_cnt`: width `$clog2(MAX_HOLD+1)`, minimum 1.
- Winner selection: the first set bit of the candidate vector, searching in the order `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4, wrapping 3 to 0).
- Every new grant, on the same clock edge:
  - `gnt` ← onehot(winner), `gnt_idx` ← winner, `gnt_valid` ← 1.
  - `owner` ← winner, `hold_cnt` ← 1, `ptr` ← winner+1 (mod 4).
- IDLE:
  - `req` == 0: stay in IDLE, outputs stay 0.
  - `req` ≠ 0: arbitrate over `req`, go to BUSY, `preempt` ← 0.
- BUSY, release (`req[owner]` == 0):
  - Arbitrate over `req` with the owner bit masked.
  - A winner exists: grant it with no idle gap, `preempt` ← 0.
  - No winner: go to IDLE; `gnt`, `gnt_idx`, `gnt_valid` ← 0.
- BUSY, forced rotation:
  - Condition: `MAX_HOLD` ≠ 0, `req[owner]` == 1, `hold_cnt` == `MAX_HOLD`, and at least one other client is requesting.
  - Grant the winner over `req` with the owner bit masked, `preempt` ← 1.
  - The preempted client keeps requesting and waits for its round-robin turn.
- BUSY, continue (otherwise):
  - Keep the grant, `preempt` ← 0.
  - `hold_cnt` increments and saturates at `MAX_HOLD`.
  - At saturation with no other requester, the owner keeps the grant indefinitely.
- Invariants, checked every cycle:
  - `gnt` is zero or one-hot.
  - `gnt_valid` == |`gnt`.
  - `gnt_idx` is the encoding of `gnt`.
  - `preempt` implies `gnt_valid`.

## Timing
- Reset value of every output and register is 0: `gnt`, `gnt_idx`, `gnt_valid`, `preempt`, `ptr`, `owner`, `hold_cnt`; FSM in IDLE.
- Assertion of `rst_n` low clears all outputs immediately, without waiting for a clock edge, including in the middle of a grant.
- The first edge after `rst_n` deasserts arbitrates normally.
- Latency from IDLE: `req` sampled on edge k, `gnt` valid after edge k; one cycle, registered.
- Handoff on release:
  - If the owner drops `req` before edge k and another client is requesting, the new `gnt` appears after edge k.
  - There is no bubble cycle and never an overlapping grant.
- Preemption: with `MAX_HOLD` = M and contention, the owner holds exactly M cycles; the next owner is valid in cycle M+1.
- Simultaneous owner release and arrival of a new request are handled in the same edge; the new request is eligible.
- `preempt` is high for exactly one cycle per forced rotation.

## Test plan
1. Reset behaviour: `rst_n`=0 with `req`=4'b1111 → all outputs 0. After `rst_n` rises, first edge gives `gnt`=0001, `gnt_idx`=0.
2. Single client: `req`=0100 for 3 cycles, then 0000 → `gnt`=0100 and `gnt_idx`=2 for 3 cycles starting one cycle after the request, then 0; FSM returns to IDLE.
3. Full contention: `MAX_HOLD`=2, `req`=1111 held → `gnt` sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001; `preempt` high in each first cycle after a rotation.
4. Wrap-around: after a grant to client 3 ends, `req`=1001 → `gnt`=0001. Then with `ptr`=1 and `req`=1001 → client 3 is granted before client 0.
5. Saturation: `MAX_HOLD`=2, only `req[1]` high for 10 cycles → `gnt`=0010 continuously and `preempt` never asserts.
6. Handoff and reset mid-grant: owner 0 drops `req` in the same cycle `req[3]` rises → next cycle `gnt`=1000 with no gap. Then pull `rst_n` low between clock edges → all outputs 0 at once.

Source files
------------

// File: rtl/rr_arbiter4.sv
// Four-client round-robin arbiter with registered one-hot grant, binary index,
// and a programmable hold limit that forces rotation under contention.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_req,
  output logic [3:0] o_gnt,
  output logic [1:0] o_gnt_idx,
  output logic       o_gnt_valid,
  output logic       o_preempt
);

  localparam int unsigned CW = (MAX_HOLD == 32'd0) ? 32'd1 : $clog2(MAX_HOLD + 32'd1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_ptr;
  logic [1:0]  r_owner;
  logic [CW-1:0] r_cnt;
  logic [3:0]  r_gnt;
  logic [1:0]  r_gnt_idx;
  logic        r_gnt_valid;
  logic        r_preempt;

  logic        w_own_req;
  logic [3:0]  w_others;
  logic [2:0]  w_pick_all;
  logic [2:0]  w_pick_oth;
  logic        w_sat;
  logic        w_grant;
  logic [1:0]  w_win;
  logic        w_pre;
  logic        w_clear;
  logic        w_inc;

  // Returns {found, index} of the first set bit searching ptr, ptr+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      res = cand[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  assign w_own_req  = i_req[r_owner];
  assign w_others   = i_req & ~(4'b0001 << r_owner);
  assign w_pick_all = rr_pick(i_req, r_ptr);
  assign w_pick_oth = rr_pick(w_others, r_ptr);
  assign w_sat      = (MAX_HOLD != 32'd0) && (r_cnt == HOLD_LIM);

  // Next-state and grant decision.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_win       = 2'b00;
    w_pre       = 1'b0;
    w_clear     = 1'b0;
    w_inc       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_all[2]) begin
          w_grant     = 1'b1;
          w_win       = w_pick_all[1:0];
          w_state_nxt = S_BUSY;
        end else begin
          w_clear     = 1'b1;
        end
      end
      S_BUSY: begin
        if (!w_own_req) begin
          if (w_pick_oth[2]) begin
            w_grant = 1'b1;
            w_win   = w_pick_oth[1:0];
          end else begin
            w_clear     = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_sat && (w_others != 4'b0000)) begin
          w_grant = 1'b1;
          w_win   = w_pick_oth[1:0];
          w_pre   = 1'b1;
        end else begin
          w_inc   = 1'b1;
        end
      end
      default: begin
        w_clear     = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, pointer, hold counter and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= 2'b00;
      r_owner     <= 2'b00;
      r_cnt       <= '0;
      r_gnt       <= 4'b0000;
      r_gnt_idx   <= 2'b00;
      r_gnt_valid <= 1'b0;
      r_preempt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_gnt       <= 4'b0001 << w_win;
        r_gnt_idx   <= w_win;
        r_gnt_valid <= 1'b1;
        r_owner     <= w_win;
        r_cnt       <= CNT_ONE;
        r_ptr       <= w_win + 2'd1;
        r_preempt   <= w_pre;
      end else if (w_clear) begin
        r_gnt       <= 4'b0000;
        r_gnt_idx   <= 2'b00;
        r_gnt_valid <= 1'b0;
        r_preempt   <= 1'b0;
      end else begin
        r_preempt <= 1'b0;
        // Counter saturates at the limit; an unlimited arbiter never counts.
        if (w_inc && (MAX_HOLD != 32'd0) && (r_cnt != HOLD_LIM)) begin
          r_cnt <= r_cnt + CNT_ONE;
        end else begin
          r_cnt <= r_cnt;
        end
      end
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_idx   = r_gnt_idx;
  assign o_gnt_valid = r_gnt_valid;
  assign o_preempt   = r_preempt;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: three instances (hold limits 2, 8, unlimited) share one
// request stream and are compared each cycle with a behavioural model.
module tb_rr_arbiter4;

  localparam int NI = 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       cmp_en;

  logic [3:0] gnt_o [NI];
  logic [1:0] idx_o [NI];
  logic       vld_o [NI];
  logic       pre_o [NI];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       busy;
    logic [1:0] owner;
    logic [1:0] ptr;
    int         cnt;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       vld;
    logic       pre;
  } mst_t;

  mst_t ms [NI];

  logic [3:0] cseq [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                           4'b0100, 4'b1000, 4'b1000, 4'b0001};
  logic [1:0] cidx [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
  logic       cpre [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  rr_arbiter4 #(.MAX_HOLD(2)) u_dut_h2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
    .o_gnt(gnt_o[0]), .o_gnt_idx(idx_o[0]), .o_gnt_valid(vld_o[0]), .o_preempt(pre_o[0]));
  rr_arbiter4 #(.MAX_HOLD(8)) u_dut_h8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
    .o_gnt(gnt_o[1]), .o_gnt_idx(idx_o[1]), .o_gnt_valid(vld_o[1]), .o_preempt(pre_o[1]));
  rr_arbiter4 #(.MAX_HOLD(0)) u_dut_h0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
    .o_gnt(gnt_o[2]), .o_gnt_idx(idx_o[2]), .o_gnt_valid(vld_o[2]), .o_preempt(pre_o[2]));

  function automatic int hold_of(int i);
    case (i)
      0:       return 2;
      1:       return 8;
      default: return 0;
    endcase
  endfunction

  function automatic mst_t zero_st();
    mst_t s;
    s.busy = 1'b0; s.owner = 2'd0; s.ptr = 2'd0; s.cnt = 0;
    s.gnt = 4'd0; s.idx = 2'd0; s.vld = 1'b0; s.pre = 1'b0;
    return s;
  endfunction

  // First requesting client in round-robin order starting at 'start', or -1.
  function automatic int first_from(logic [3:0] cand, int start);
    int j;
    for (int k = 0; k < 4; k++) begin
      j = (start + k) % 4;
      if (cand[j]) return j;
    end
    return -1;
  endfunction

  function automatic mst_t give(mst_t s, int w, logic p);
    mst_t n = s;
    n.busy = 1'b1; n.owner = 2'(w); n.ptr = 2'((w + 1) % 4); n.cnt = 1;
    n.gnt = 4'(1 << w); n.idx = 2'(w); n.vld = 1'b1; n.pre = p;
    return n;
  endfunction

  function automatic mst_t idle_st(mst_t s);
    mst_t n = s;
    n.busy = 1'b0; n.gnt = 4'd0; n.idx = 2'd0; n.vld = 1'b0; n.pre = 1'b0;
    return n;
  endfunction

  function automatic mst_t model_step(mst_t s, logic [3:0] r, int m);
    mst_t n = s;
    logic [3:0] oth;
    int w;
    n.pre = 1'b0;
    oth = r;
    oth[s.owner] = 1'b0;
    if (!s.busy) begin
      w = first_from(r, int'(s.ptr));
      n = (w >= 0) ? give(s, w, 1'b0) : idle_st(s);
    end else if (!r[s.owner]) begin
      w = first_from(oth, int'(s.ptr));
      n = (w >= 0) ? give(s, w, 1'b0) : idle_st(s);
    end else if (m != 0 && s.cnt == m && oth != 4'd0) begin
      n = give(s, first_from(oth, int'(s.ptr)), 1'b1);
    end else if (m != 0 && s.cnt < m) begin
      n.cnt = s.cnt + 1;
    end
    return n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      ms[i] <= rst_n ? model_step(ms[i], req, hold_of(i)) : zero_st();
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("model_gnt[%0d]", i), 32'(gnt_o[i]), 32'(ms[i].gnt));
        chk($sformatf("model_idx[%0d]", i), 32'(idx_o[i]), 32'(ms[i].idx));
        chk($sformatf("model_vld[%0d]", i), 32'(vld_o[i]), 32'(ms[i].vld));
        chk($sformatf("model_pre[%0d]", i), 32'(pre_o[i]), 32'(ms[i].pre));
      end
    end
  end

  task automatic chk_all_zero(string name);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_gnt[%0d]", name, i), 32'(gnt_o[i]), 32'd0);
      chk($sformatf("%s_idx[%0d]", name, i), 32'(idx_o[i]), 32'd0);
      chk($sformatf("%s_vld[%0d]", name, i), 32'(vld_o[i]), 32'd0);
      chk($sformatf("%s_pre[%0d]", name, i), 32'(pre_o[i]), 32'd0);
    end
  endtask

  initial begin
    int hold_len;
    rst_n  = 1'b1;
    req    = 4'b0000;
    cmp_en = 1'b0;
    #1 rst_n = 1'b0;
    req = 4'b1111;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    cmp_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Full contention on the hold-2 instance, starting from the first edge after reset.
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      chk("contention_gnt", 32'(gnt_o[0]), 32'(cseq[k]));
      chk("contention_idx", 32'(idx_o[0]), 32'(cidx[k]));
      chk("contention_pre", 32'(pre_o[0]), 32'(cpre[k]));
    end
    req = 4'b0000;
    @(posedge clk); #1 chk_all_zero("to_idle");

    req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("single_gnt", 32'(gnt_o[1]), 32'h4);
      chk("single_idx", 32'(idx_o[1]), 32'd2);
    end
    req = 4'b0000;
    @(posedge clk); #1;
    chk("single_end_gnt", 32'(gnt_o[1]), 32'd0);
    chk("single_end_vld", 32'(vld_o[1]), 32'd0);

    req = 4'b1000;
    @(posedge clk); #1 req = 4'b0000;
    @(posedge clk); #1 req = 4'b1001;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) chk($sformatf("wrap_to0[%0d]", i), 32'(gnt_o[i]), 32'h1);
    req = 4'b0000;
    @(posedge clk); #1 req = 4'b1001;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) chk($sformatf("wrap_to3[%0d]", i), 32'(gnt_o[i]), 32'h8);
    req = 4'b0000;
    @(posedge clk); #1;

    req = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("sat_gnt", 32'(gnt_o[0]), 32'h2);
      chk("sat_pre", 32'(pre_o[0]), 32'd0);
    end
    req = 4'b0000;
    @(posedge clk); #1 req = 4'b0001;
    repeat (2) @(posedge clk);
    #1 chk("handoff_pre_owner", 32'(gnt_o[1]), 32'h1);
    req = 4'b1000;
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("handoff_gnt[%0d]", i), 32'(gnt_o[i]), 32'h8);
      chk($sformatf("handoff_pre[%0d]", i), 32'(pre_o[i]), 32'd0);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0000;

    // Random phase: requests held for random streaks, occasional mid-cycle resets.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      case ($urandom_range(0, 3))
        0:       req = 4'b1111;
        1:       req = 4'b0000;
        default: req = 4'($urandom);
      endcase
      hold_len = $urandom_range(1, 12);
      repeat (hold_len - 1) @(negedge clk);
      if ($urandom_range(0, 99) == 0) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
